// File: rtl/autocorrelation_pkg.sv
// Shared types and default sizing for the LPC autocorrelation datapath
// (sequencer, MAC and R(k) coefficient store).
package autocorrelation_pkg;

    localparam int unsigned DEF_FRAME_LEN = 256;
    localparam int unsigned DEF_ORDER     = 10;
    localparam int unsigned DEF_RD_LAT    = 1;
    localparam int unsigned DEF_MAC_LAT   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } acs_state_e;

endpackage

// File: rtl/autocorrelation_delay.sv
// WIDTH x DEPTH shift register with synchronous flush; DEPTH=0 is a wire.
module autocorrelation_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctl;
        assign unused_ctl = ^{clk, reset_n, flush};
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else if (flush) begin
                for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= d;
                for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/autocorrelation_sequencer.sv
// Walks lags k=0..P over a buffered frame, issuing (n, n-k) read pairs and
// latency-aligned MAC clear/enable and per-lag result-write strobes.
module autocorrelation_sequencer
    import autocorrelation_pkg::*;
#(
    parameter  int unsigned FRAME_LEN = DEF_FRAME_LEN,
    parameter  int unsigned ORDER     = DEF_ORDER,
    parameter  int unsigned RD_LAT    = DEF_RD_LAT,
    parameter  int unsigned MAC_LAT   = DEF_MAC_LAT,
    localparam int unsigned ADDR_W    = $clog2(FRAME_LEN),
    localparam int unsigned LAG_W     = $clog2(ORDER + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LAG_W-1:0]  order,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] raddr_a,
    output logic [ADDR_W-1:0] raddr_b,
    output logic [LAG_W-1:0]  lag,
    output logic              acc_clear,
    output logic              acc_en,
    output logic              r_we,
    output logic [LAG_W-1:0]  r_waddr
);

    localparam int unsigned TOT_LAT = RD_LAT + MAC_LAT;
    localparam int unsigned CNT_W   = (TOT_LAT > 1) ? $clog2(TOT_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_N  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [LAG_W-1:0]  ORDER_L = LAG_W'(ORDER);

    acs_state_e        state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [LAG_W-1:0]  k_q, k_d, p_q, p_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_d, first_d, last_d, done_d;
    logic              first_q, last_q;
    logic [1:0]        acc_dly;
    logic [LAG_W:0]    wr_dly;

    // Next-state and next-output decode
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    n_d     = '0;
                    k_d     = '0;
                    p_d     = (order > ORDER_L) ? ORDER_L : order;
                end
            end
            ST_RUN: begin
                if (n_q == LAST_N) begin
                    if (k_q == p_q) begin
                        n_d = '0;
                        k_d = '0;
                        if (TOT_LAT == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DRAIN;
                            cnt_d   = CNT_W'(TOT_LAT - 1);
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                        n_d = ADDR_W'(k_q) + 1'b1;
                    end
                end else begin
                    n_d = n_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            n_d     = '0;
            k_d     = '0;
            cnt_d   = '0;
        end
        run_d   = (state_d == ST_RUN);
        first_d = run_d && (n_d == ADDR_W'(k_d));
        last_d  = run_d && (n_d == LAST_N);
        // Zero total latency: done rides on the final read cycle itself
        if (TOT_LAT == 0) done_d = last_d && (k_d == p_d);
        else              done_d = (state_d == ST_DRAIN) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            raddr_a <= '0;
            raddr_b <= '0;
            lag     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d != ST_IDLE);
            done    <= done_d;
            rd_en   <= run_d;
            raddr_a <= run_d ? n_d : '0;
            raddr_b <= run_d ? (n_d - ADDR_W'(k_d)) : '0;
            lag     <= run_d ? k_d : '0;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    autocorrelation_delay #(
        .WIDTH (2),
        .DEPTH (RD_LAT)
    ) u_dly_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (abort),
        .d       ({first_q, rd_en}),
        .q       (acc_dly)
    );

    autocorrelation_delay #(
        .WIDTH (LAG_W + 1),
        .DEPTH (TOT_LAT)
    ) u_dly_wr (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (abort),
        .d       ({last_q, lag}),
        .q       (wr_dly)
    );

    assign acc_clear = acc_dly[1];
    assign acc_en    = acc_dly[0];
    assign r_we      = wr_dly[LAG_W];
    assign r_waddr   = wr_dly[LAG_W-1:0];

endmodule

// File: tb/tb_autocorrelation_sequencer.sv
// Scoreboard bench: expected per-cycle output records are queued at start,
// monitors pop and compare them whenever a sequencer shows activity.
module tb_autocorrelation_sequencer;

    localparam int FL  = 8;
    localparam int ORD = 2;
    localparam int AW  = 3;
    localparam int LW  = 2;

    typedef struct packed {
        logic          busy;
        logic          rd_en;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [LW-1:0] lag;
        logic          clr;
        logic          en;
        logic          we;
        logic [LW-1:0] wa;
        logic          done;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic          start1 = 1'b0, abort1 = 1'b0;
    logic [LW-1:0] order1 = '0;
    logic          busy1, done1, rd_en1, acc_clear1, acc_en1, r_we1;
    logic [AW-1:0] raddr_a1, raddr_b1;
    logic [LW-1:0] lag1, r_waddr1;

    logic          start2 = 1'b0, abort2 = 1'b0;
    logic [LW-1:0] order2 = '0;
    logic          busy2, done2, rd_en2, acc_clear2, acc_en2, r_we2;
    logic [AW-1:0] raddr_a2, raddr_b2;
    logic [LW-1:0] lag2, r_waddr2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    autocorrelation_sequencer #(
        .FRAME_LEN (FL), .ORDER (ORD), .RD_LAT (1), .MAC_LAT (1)
    ) dut1 (
        .clk (clk), .reset_n (reset_n), .start (start1), .order (order1), .abort (abort1),
        .busy (busy1), .done (done1), .rd_en (rd_en1), .raddr_a (raddr_a1), .raddr_b (raddr_b1),
        .lag (lag1), .acc_clear (acc_clear1), .acc_en (acc_en1), .r_we (r_we1), .r_waddr (r_waddr1)
    );

    autocorrelation_sequencer #(
        .FRAME_LEN (FL), .ORDER (ORD), .RD_LAT (0), .MAC_LAT (0)
    ) dut2 (
        .clk (clk), .reset_n (reset_n), .start (start2), .order (order2), .abort (abort2),
        .busy (busy2), .done (done2), .rd_en (rd_en2), .raddr_a (raddr_a2), .raddr_b (raddr_b2),
        .lag (lag2), .acc_clear (acc_clear2), .acc_en (acc_en2), .r_we (r_we2), .r_waddr (r_waddr2)
    );

    function automatic void check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    function automatic obs_t mask(input obs_t o);
        obs_t m;
        m = o;
        if (!m.rd_en) begin
            m.a   = '0;
            m.b   = '0;
            m.lag = '0;
        end
        if (!m.we) m.wa = '0;
        return m;
    endfunction

    function automatic obs_t obs1();
        obs_t o;
        o = '{busy: busy1, rd_en: rd_en1, a: raddr_a1, b: raddr_b1, lag: lag1,
              clr: acc_clear1, en: acc_en1, we: r_we1, wa: r_waddr1, done: done1};
        return o;
    endfunction

    function automatic obs_t obs2();
        obs_t o;
        o = '{busy: busy2, rd_en: rd_en2, a: raddr_a2, b: raddr_b2, lag: lag2,
              clr: acc_clear2, en: acc_en2, we: r_we2, wa: r_waddr2, done: done2};
        return o;
    endfunction

    // Expected timeline of one run: reads at rel cycles 1.., strobes shifted by latency
    task automatic push_run(input int dut, input int base, input int p, input int rl,
                            input int ml, input int cut);
        obs_t r[64];
        int   c;
        int   lt;
        lt = rl + ml;
        for (int i = 0; i < 64; i++) r[i] = '0;
        c = 1;
        for (int k = 0; k <= p; k++) begin
            for (int n = k; n < FL; n++) begin
                r[c].rd_en = 1'b1;
                r[c].a     = AW'(n);
                r[c].b     = AW'(n - k);
                r[c].lag   = LW'(k);
                r[c+rl].en = 1'b1;
                if (n == k) r[c+rl].clr = 1'b1;
                if (n == FL - 1) begin
                    r[c+lt].we = 1'b1;
                    r[c+lt].wa = LW'(k);
                end
                c++;
            end
        end
        r[c-1+lt].done = 1'b1;
        for (int i = 1; i <= c - 1 + lt; i++) begin
            r[i].busy = 1'b1;
            if (i <= cut) begin
                exp_t e;
                e.cyc = base + i;
                e.o   = r[i];
                if (dut == 1) q1.push_back(e);
                else          q2.push_back(e);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon1
        obs_t o;
        exp_t e;
        o = mask(obs1());
        if (o != '0) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected activity", 32'(o), 0);
            end else begin
                e = q1.pop_front();
                check("dut1 cycle", cyc, e.cyc);
                check($sformatf("dut1 outputs @%0d", e.cyc), 32'(o), 32'(e.o));
            end
        end
    end

    always @(negedge clk) begin : mon2
        obs_t o;
        exp_t e;
        o = mask(obs2());
        if (o != '0) begin
            if (q2.size() == 0) begin
                check("dut2 unexpected activity", 32'(o), 0);
            end else begin
                e = q2.pop_front();
                check("dut2 cycle", cyc, e.cyc);
                check($sformatf("dut2 outputs @%0d", e.cyc), 32'(o), 32'(e.o));
            end
        end
    end

    initial begin
        step(2);
        check("reset dut1 outputs", 32'(obs1()), 0);
        check("reset dut2 outputs", 32'(obs2()), 0);
        reset_n = 1'b1;
        step(2);

        // Full order-2 run on dut1, order-1 zero-latency run on dut2
        t0 = cyc;
        order1 = 2'd2; order2 = 2'd1; start1 = 1'b1; start2 = 1'b1;
        push_run(1, t0, 2, 1, 1, 1000);
        push_run(2, t0, 1, 0, 0, 1000);
        step(1);
        start1 = 1'b0; start2 = 1'b0;
        step(2);
        order1 = 2'd0;
        step(2);
        start1 = 1'b1;
        step(1);
        start1 = 1'b0;
        step(t0 + 23 - cyc);
        check("busy in done cycle", 32'(busy1), 1);
        check("done at cycle 23", 32'(done1), 1);
        step(1);
        check("busy low at cycle 24", 32'(busy1), 0);
        step(2);

        // Order 0
        t0 = cyc;
        order1 = 2'd0; start1 = 1'b1;
        push_run(1, t0, 0, 1, 1, 1000);
        step(1);
        start1 = 1'b0;
        step(12);

        // Order 3 clamps to 2
        t0 = cyc;
        order1 = 2'd3; start1 = 1'b1;
        push_run(1, t0, 2, 1, 1, 1000);
        step(1);
        start1 = 1'b0;
        step(26);

        // Abort at rel cycle 12, restart at 14
        t0 = cyc;
        order1 = 2'd2; start1 = 1'b1;
        push_run(1, t0, 2, 1, 1, 12);
        step(1);
        start1 = 1'b0;
        step(11);
        abort1 = 1'b1;
        step(1);
        abort1 = 1'b0;
        check("busy after abort", 32'(busy1), 0);
        step(1);
        start1 = 1'b1;
        push_run(1, cyc, 2, 1, 1, 1000);
        step(1);
        start1 = 1'b0;
        step(26);

        // start together with abort is dropped
        start1 = 1'b1; abort1 = 1'b1;
        step(1);
        start1 = 1'b0; abort1 = 1'b0;
        check("busy after start+abort", 32'(busy1), 0);
        step(3);

        // Asynchronous reset in the middle of a run
        t0 = cyc;
        order1 = 2'd2; start1 = 1'b1;
        push_run(1, t0, 2, 1, 1, 4);
        step(1);
        start1 = 1'b0;
        step(4);
        #1 reset_n = 1'b0;
        #1 check("async reset outputs", 32'(obs1()), 0);
        step(1);
        reset_n = 1'b1;
        step(2);
        check("idle after reset release", 32'(busy1), 0);

        t0 = cyc;
        order1 = 2'd0; start1 = 1'b1;
        push_run(1, t0, 0, 1, 1, 1000);
        step(1);
        start1 = 1'b0;
        step(14);

        check("dut1 expected records left", q1.size(), 0);
        check("dut2 expected records left", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
